// File: rtl/inv_sub_bytes_pipe.sv
// inv_sub_bytes_pipe: two-stage valid/ready AES InvSubBytes over LANES byte lanes.
module inv_sub_bytes_pipe #(
  parameter int LANES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);
  // inverse S-box as four quarter tables indexed by byte[5:0], quarter chosen by byte[7:6]
  localparam logic [7:0] isb [4][64] = '{
    '{8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
      8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
      8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
      8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
      8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25},
    '{8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
      8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
      8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
      8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
      8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b},
    '{8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
      8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
      8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
      8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
      8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4},
    '{8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
      8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
      8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
      8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
      8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d}
  };
  logic va, vb, adv_a, adv_b;
  logic [LANES-1:0][3:0][7:0] cand, cand_d;
  logic [LANES-1:0][1:0] sel, sel_d;
  logic [LANES-1:0][7:0] pick;
  assign adv_b = !vb || out_ready;
  assign adv_a = !va || adv_b;
  assign in_ready = adv_a;
  assign out_valid = vb;
  assign busy = va || vb;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    for (genvar q = 0; q < 4; q++) begin : g_quarter
      assign cand_d[i][q] = isb[q][in_data[8*i +: 6]];
    end
    assign sel_d[i] = in_data[8*i+6 +: 2];
    assign pick[i] = cand[i][sel[i]];
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      va <= 1'b0;
      vb <= 1'b0;
      cand <= '0;
      sel <= '0;
      out_data <= '0;
    end else if (clr) begin
      va <= 1'b0;
      vb <= 1'b0;
    end else begin
      if (adv_a) va <= in_valid;
      if (adv_b) vb <= va;
      if (adv_a && in_valid) begin
        cand <= cand_d;
        sel <= sel_d;
      end
      if (adv_b && va) out_data <= pick;
    end
  end
endmodule

// File: tb/tb_inv_sub_bytes_pipe.sv
// tb_inv_sub_bytes_pipe: scoreboard bench; reference inverse S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_bytes_pipe;
  localparam int W = 128;
  logic clk = 1'b0;
  logic rst, clr, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0] in_data, out_data;
  int total = 0, bad = 0, n_out = 0;
  logic [W-1:0] q[$], qi[$];
  logic [7:0] fwd [256];
  logic [7:0] isb_m [256];

  inv_sub_bytes_pipe #(.LANES(16)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] x, y, p;
    x = a;
    y = b;
    p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [W-1:0] inv_word(logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = isb_m[w[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [W-1:0] fwd_word(logic [W-1:0] w);
    logic [W-1:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd[w[8*i +: 8]];
    return r;
  endfunction

  task automatic chk(string tag, logic [W-1:0] got, logic [W-1:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // called just after a falling edge with inputs set; scores the handshakes of this cycle
  task automatic cyc(output bit acc);
    logic [W-1:0] e, iw;
    #1;
    acc = in_valid && in_ready && !clr && rst;
    if (acc) begin
      q.push_back(inv_word(in_data));
      qi.push_back(in_data);
    end
    if (out_valid && out_ready) begin
      chk("sb_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        iw = qi.pop_front();
        chk("data", out_data, e);
        chk("roundtrip", fwd_word(out_data), iw);
        n_out++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick();
    bit d;
    cyc(d);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) tick();
    chk("drain", q.size(), 0);
  endtask

  task automatic single(logic [W-1:0] d, logic [W-1:0] e);
    in_data = d;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 chk("lat1_valid", out_valid, 0);
    tick();
    chk("lat2_valid", out_valid, 1);
    chk("lat2_data", out_data, e);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] iw, ew, hold;
    logic [7:0] inv, pi [4], pe [4];
    bit acc;
    int n0, na;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fwd[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) isb_m[fwd[x]] = 8'(x);
    rst = 1'b0;
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    // directed words with literal expectations
    single(128'h0f0e0d0c0b0a09080706050403020100, 128'hfbd7f3819ea340bf38a53630d56a0952);
    single({16{8'h63}}, {16{8'h00}});
    single({16{8'h16}}, {16{8'hff}});
    pi = '{8'hed, 8'h52, 8'h01, 8'h7c};
    pe = '{8'h53, 8'h48, 8'h09, 8'h01};
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 16; i++) begin
        iw[8*i +: 8] = pi[(i + r) % 4];
        ew[8*i +: 8] = pe[(i + r) % 4];
      end
      single(iw, ew);
    end
    // backpressure: two words fill the pipe, third must wait
    n0 = n_out;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 128'h00112233445566778899aabbccddeeff;
    tick();
    in_data = 128'hffeeddccbbaa99887766554433221100;
    tick();
    in_data = 128'h0123456789abcdef0123456789abcdef;
    #1;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_busy", busy, 1);
    chk("bp_head", out_data, inv_word(128'h00112233445566778899aabbccddeeff));
    hold = out_data;
    repeat (3) tick();
    chk("bp_stable", out_data, hold);
    chk("bp_held", q.size(), 2);
    out_ready = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 5 && !acc; c++) cyc(acc);
    chk("bp_acc3", acc, 1);
    drain();
    chk("bp_count", n_out - n0, 3);
    // streaming with random backpressure
    n0 = n_out;
    for (int k = 0; k < 256; k++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_data[7:0] = 8'(k);
      in_valid = 1'b1;
      acc = 1'b0;
      for (int c = 0; c < 50 && !acc; c++) begin
        out_ready = 1'($urandom_range(0, 1));
        cyc(acc);
      end
      chk("stream_acc", acc, 1);
    end
    drain();
    chk("stream_count", n_out - n0, 256);
    // clr with two words in flight
    n0 = n_out;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 128'h11111111222222223333333344444444;
    tick();
    in_data = 128'h55555555666666667777777788888888;
    tick();
    in_valid = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_busy", busy, 0);
    q.delete();
    qi.delete();
    // clr drops a handshake offered while in_ready is high
    in_valid = 1'b1;
    in_data = 128'h99999999aaaaaaaabbbbbbbbcccccccc;
    clr = 1'b1;
    #1 chk("clr_in_ready", in_ready, 1);
    tick();
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("clr_no_output", n_out - n0, 0);
    chk("clr_busy2", busy, 0);
    // async reset mid-operation
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    tick();
    in_data = 128'hcafef00dcafef00dcafef00dcafef00d;
    tick();
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete();
    qi.delete();
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("arst_no_output", n_out - n0, 0);
    // full pipe with simultaneous accept, shift and emit
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    in_data = {$urandom, $urandom, $urandom, $urandom};
    tick();
    #1 chk("sim_full", in_ready, 0);
    out_ready = 1'b1;
    n0 = n_out;
    na = 0;
    for (int c = 0; c < 10; c++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      cyc(acc);
      na += int'(acc);
    end
    chk("sim_acc", na, 10);
    chk("sim_out", n_out - n0, 10);
    drain();
    chk("final_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
